// File: rtl/dense_argmax.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dense_argmax
// Description : Classifier stage after the dense layer. Collects NUM_CLASSES
//               serial signed scores, tracks the maximum (ties keep the lower
//               index) and holds the winning index and score under a
//               valid/ready handshake until the consumer takes it.
//               Optional feature macro: TOP2_MARGIN_EN adds a runner-up
//               tracker and the class_margin output (max - runner_up).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module dense_argmax #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              busy,
    output logic              drop_err
`ifdef TOP2_MARGIN_EN
    ,
    output logic [DATA_W:0]   class_margin
`endif
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_HOLD    = 2'd2;

    // A one-score vector is complete as soon as its first sample lands
    localparam bit         c_SINGLE   = (NUM_CLASSES == 1);
    localparam logic [1:0] c_ST_FIRST = c_SINGLE ? c_ST_HOLD : c_ST_COLLECT;

    // Stream position of the final score in a vector
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic signed [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_count;
    logic                     r_drop_err;

    logic                     w_start;   // sample taken as element 0 of a vector
    logic                     w_accum;   // sample taken as element 1..N-1
    logic                     w_drop;    // sample discarded while result held
    logic                     w_gt_max;  // strict signed greater-than current max

    assign w_gt_max = $signed(in_data) > r_max;

    // Next-state and per-cycle sample classification; abort dominates everything
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accum     = 1'b0;
        w_drop      = 1'b0;
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        w_start     = 1'b1;
                        w_state_nxt = c_ST_FIRST;
                    end
                end
                c_ST_COLLECT: begin
                    if (in_valid) begin
                        w_accum = 1'b1;
                        if (r_count == c_LAST_IDX) begin
                            w_state_nxt = c_ST_HOLD;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (out_ready) begin
                        // Handoff; a coincident sample opens the next vector
                        if (in_valid) begin
                            w_start     = 1'b1;
                            w_state_nxt = c_ST_FIRST;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else if (in_valid) begin
                        w_drop = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sample counter: restarts per vector, cleared on abort and on return to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (abort) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= IDX_W'(1);
        end else if (w_accum) begin
            r_count <= r_count + 1'b1;
        end else if (w_state_nxt == c_ST_IDLE) begin
            r_count <= '0;
        end
    end

    // Running maximum and its index; strict compare keeps the earliest winner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (w_start) begin
            r_max <= $signed(in_data);
            r_idx <= '0;
        end else if (w_accum && w_gt_max) begin
            r_max <= $signed(in_data);
            r_idx <= r_count;
        end
    end

    // Sticky overflow flag: only reset clears it, abort leaves it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_err <= 1'b0;
        end else if (w_drop) begin
            r_drop_err <= 1'b1;
        end
    end

`ifdef TOP2_MARGIN_EN
    // Most negative score; seeds the runner-up so any second sample replaces it
    localparam logic signed [DATA_W-1:0] c_SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] r_second;
    logic signed [DATA_W-1:0] w_second_seed;
    logic                     w_gt_second;

    // With a single class there is no runner-up, so seed with the max itself
    assign w_second_seed = c_SINGLE ? $signed(in_data) : c_SCORE_MIN;
    assign w_gt_second   = $signed(in_data) > r_second;

    // Runner-up tracker: a new max demotes the old one, else compete for second
    always_ff @(posedge clk) begin
        if (rst) begin
            r_second <= '0;
        end else if (w_start) begin
            r_second <= w_second_seed;
        end else if (w_accum) begin
            if (w_gt_max) begin
                r_second <= r_max;
            end else if (w_gt_second) begin
                r_second <= $signed(in_data);
            end
        end
    end

    // Sign-extended difference; max >= runner-up so the result is non-negative
    assign class_margin = {r_max[DATA_W-1], r_max} - {r_second[DATA_W-1], r_second};
`endif

    assign out_valid   = (r_state == c_ST_HOLD);
    assign busy        = (r_state == c_ST_COLLECT);
    assign class_idx   = r_idx;
    assign class_score = r_max;
    assign drop_err    = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_dense_argmax.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_dense_argmax
// Description : Directed self-checking bench for dense_argmax.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dense_argmax;

    localparam int DATA_W      = 16;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              abort;
    logic              out_ready;
    logic              out_valid;
    logic [IDX_W-1:0]  class_idx;
    logic [DATA_W-1:0] class_score;
    logic              busy;
    logic              drop_err;
`ifdef TOP2_MARGIN_EN
    logic [DATA_W:0]   class_margin;
`endif

    int errors;
    int checks;

    dense_argmax #(
        .DATA_W      (DATA_W),
        .NUM_CLASSES (NUM_CLASSES),
        .IDX_W       (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .abort       (abort),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .class_idx   (class_idx),
        .class_score (class_score),
        .busy        (busy),
        .drop_err    (drop_err)
`ifdef TOP2_MARGIN_EN
        ,
        .class_margin(class_margin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b b=%b d=%b want 0 0 0", out_valid, busy, drop_err);
        end
        checks++;
        if (class_idx !== 4'd0 || class_score !== 16'd0) begin
            errors++;
            $display("FAIL reset_result got idx=%0d score=%0d want 0 0", class_idx, class_score);
        end
        rst = 1'b0;
    endtask

    // Scenario 1: back-to-back scores, tie on 9 keeps index 2
    task automatic test_basic();
        logic [DATA_W-1:0] v [10];
        v = '{16'd5, -16'sd3, 16'd9, 16'd2, 16'd0, 16'd1, 16'd7, 16'd9, -16'sd8, 16'd4};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(v[i]);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_before_last got v=%b b=%b want v=0 b=1", out_valid, busy);
        end
        send(v[9]);
        checks++;
        if (out_valid !== 1'b1 || class_idx !== 4'd2 || $signed(class_score) !== 16'sd9) begin
            errors++;
            $display("FAIL basic_result got v=%b idx=%0d score=%0d want 1 2 9",
                     out_valid, class_idx, $signed(class_score));
        end
`ifdef TOP2_MARGIN_EN
        checks++;
        if (class_margin !== 17'd0) begin
            errors++;
            $display("FAIL basic_margin got %0d want 0", class_margin);
        end
`endif
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_handoff got out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    // Scenario 2: all scores at the most negative value
    task automatic test_all_min();
        for (int i = 0; i < 10; i++) send(16'h8000);
        checks++;
        if (out_valid !== 1'b1 || class_idx !== 4'd0 || class_score !== 16'h8000) begin
            errors++;
            $display("FAIL allmin_result got v=%b idx=%0d score=%0d want 1 0 -32768",
                     out_valid, class_idx, $signed(class_score));
        end
`ifdef TOP2_MARGIN_EN
        checks++;
        if (class_margin !== 17'd0) begin
            errors++;
            $display("FAIL allmin_margin got %0d want 0", class_margin);
        end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Scenario 3: gaps of 0..3 idle cycles between samples, max 100 last
    task automatic test_gaps();
        logic [DATA_W-1:0] v [10];
        int busy_bad;
        v = '{16'd10, 16'd20, -16'sd5, 16'd30, 16'd40, -16'sd100, 16'd50, 16'd60, 16'd70, 16'd100};
        busy_bad = 0;
        for (int i = 0; i < 10; i++) begin
            send(v[i]);
            if (i < 9) begin
                if (busy !== 1'b1) busy_bad++;
                for (int g = 0; g < (i % 4); g++) begin
                    tick();
                    if (busy !== 1'b1 || out_valid !== 1'b0) busy_bad++;
                end
            end
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL gaps_busy got %0d bad cycles want 0", busy_bad);
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || class_idx !== 4'd9 || $signed(class_score) !== 16'sd100) begin
            errors++;
            $display("FAIL gaps_result got v=%b b=%b idx=%0d score=%0d want 1 0 9 100",
                     out_valid, busy, class_idx, $signed(class_score));
        end
`ifdef TOP2_MARGIN_EN
        checks++;
        if (class_margin !== 17'd30) begin
            errors++;
            $display("FAIL gaps_margin got %0d want 30", class_margin);
        end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Scenario 4: stalled consumer, stray sample is dropped and flagged
    task automatic test_drop();
        logic [DATA_W-1:0] v [10];
        int hold_bad;
        v = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
        for (int i = 0; i < 10; i++) send(v[i]);
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_before got %b want 0", drop_err);
        end
        hold_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) send(16'd127);
            else tick();
            if (out_valid !== 1'b1 || class_idx !== 4'd5 || $signed(class_score) !== 16'sd9) hold_bad++;
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL drop_hold got %0d unstable cycles want 0", hold_bad);
        end
        checks++;
        if (drop_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_flag got %b want 1", drop_err);
        end
`ifdef TOP2_MARGIN_EN
        checks++;
        if (class_margin !== 17'd3) begin
            errors++;
            $display("FAIL drop_margin got %0d want 3", class_margin);
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (drop_err !== 1'b0 || out_valid !== 1'b0 || class_idx !== 4'd0 || class_score !== 16'd0) begin
            errors++;
            $display("FAIL drop_rst got d=%b v=%b idx=%0d score=%0d want 0 0 0 0",
                     drop_err, out_valid, class_idx, class_score);
        end
    endtask

    // Scenario 5: next vector's first score coincides with the handoff
    task automatic test_back_to_back();
        logic [DATA_W-1:0] a [10];
        logic [DATA_W-1:0] b [10];
        a = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, -16'sd1};
        b = '{-16'sd10, -16'sd20, -16'sd30, -16'sd5, -16'sd40, -16'sd50, -16'sd60, -16'sd70, -16'sd80, -16'sd90};
        for (int i = 0; i < 10; i++) send(a[i]);
        checks++;
        if (out_valid !== 1'b1 || class_idx !== 4'd8 || $signed(class_score) !== 16'sd8) begin
            errors++;
            $display("FAIL b2b_first got v=%b idx=%0d score=%0d want 1 8 8",
                     out_valid, class_idx, $signed(class_score));
        end
        out_ready = 1'b1;
        send(b[0]);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handoff got v=%b b=%b want 0 1", out_valid, busy);
        end
        for (int i = 1; i < 10; i++) send(b[i]);
        checks++;
        if (out_valid !== 1'b1 || class_idx !== 4'd3 || $signed(class_score) !== -16'sd5) begin
            errors++;
            $display("FAIL b2b_second got v=%b idx=%0d score=%0d want 1 3 -5",
                     out_valid, class_idx, $signed(class_score));
        end
`ifdef TOP2_MARGIN_EN
        checks++;
        if (class_margin !== 17'd5) begin
            errors++;
            $display("FAIL b2b_margin got %0d want 5", class_margin);
        end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Scenario 6: abort a partial vector, then a full one; abort also beats handoff
    task automatic test_abort();
        logic [DATA_W-1:0] v [10];
        v = '{16'd10, 16'd20, 16'd5, 16'd30, 16'd0, -16'sd1, 16'd50, 16'd7, 16'd8, 16'd9};
        send(16'd1000);
        send(16'd2000);
        send(16'd3000);
        send(16'd4000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_partial got b=%b v=%b want 0 0", busy, out_valid);
        end
        for (int i = 0; i < 9; i++) send(v[i]);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_early_valid got %b want 0", out_valid);
        end
        send(v[9]);
        checks++;
        if (out_valid !== 1'b1 || class_idx !== 4'd6 || $signed(class_score) !== 16'sd50) begin
            errors++;
            $display("FAIL abort_result got v=%b idx=%0d score=%0d want 1 6 50",
                     out_valid, class_idx, $signed(class_score));
        end
`ifdef TOP2_MARGIN_EN
        checks++;
        if (class_margin !== 17'd20) begin
            errors++;
            $display("FAIL abort_margin got %0d want 20", class_margin);
        end
`endif
        abort     = 1'b1;
        out_ready = 1'b1;
        send(16'd77);
        abort     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_override got v=%b b=%b d=%b want 0 0 0", out_valid, busy, drop_err);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_all_min();
        test_gaps();
        test_drop();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
